// File: rtl/uart_boot_loader_pkg.sv
// boot_loader_pkg: shared state encodings and word geometry for the UART boot loader
package boot_loader_pkg;
  typedef enum logic [2:0] {L_IDLE, L_CNT0, L_CNT1, L_BYTE, L_WRITE, L_DONE} ldr_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: instruction-memory write port driven by the loader
interface uart_boot_loader_if;
  logic        cs;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        drive;
  modport master (output cs, we, addr, wdata, drive);
  modport slave  (input  cs, we, addr, wdata, drive);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and framing-error detection
module uart_rx_core
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_t st_q, st_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic vld_q, vld_d, ferr_q, ferr_d;
  logic line;
  assign line = sync_q[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      st_q   <= R_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ser_i};
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
      ferr_q <= ferr_d;
    end
  end
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + 1'b1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        st_d  = line ? R_IDLE : R_START;
      end
      R_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = line ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {line, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        st_d  = (bit_q == 3'd7) ? R_STOP : R_DATA;
      end
      R_STOP: if (cnt_q == FULL) begin
        cnt_d  = '0;
        vld_d  = line;
        ferr_d = !line;
        st_d   = line ? R_IDLE : R_WAITHI;
      end
      R_WAITHI: begin
        cnt_d = '0;
        st_d  = line ? R_IDLE : R_WAITHI;
      end
      default: st_d = R_IDLE;
    endcase
  end
  assign rx_byte_o  = sh_q;
  assign rx_valid_o = vld_q;
  assign rx_ferr_o  = ferr_q;
  assign rx_busy_o  = st_q != R_IDLE;
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a counted UART image and writes it word by word into instruction memory while holding the CPU
module uart_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int          CLK_FREQ     = 100_000_000,
  parameter int          BAUD         = 115_200,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          MAX_WORDS    = 1024,
  parameter int          TIMEOUT_BITS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ser_i,
  input  logic               start_i,
  uart_boot_loader_if.master mem,
  output logic               cpu_hold_o,
  output logic               load_done_o,
  output logic               load_err_o,
  output logic [15:0]        words_rx_o
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int TO  = TIMEOUT_BITS * CPB;
  localparam int TW  = $clog2(TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO - 1);
  ldr_state_t st_q, st_d;
  logic [7:0] rx_byte;
  logic rx_valid, rx_ferr, rx_busy;
  logic [15:0] cnt_q, cnt_d, words_q, words_d, cnt_rx;
  logic [1:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic err_q, err_d;
  logic [TW-1:0] to_q, to_d;
  logic loading, silent, tmo, wr;
  uart_rx_core #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_i     (ser_i),
    .rx_byte_o (rx_byte),
    .rx_valid_o(rx_valid),
    .rx_ferr_o (rx_ferr),
    .rx_busy_o (rx_busy)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= L_CNT0;
      cnt_q   <= '0;
      words_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end
  assign loading = st_q == L_CNT1 || st_q == L_BYTE;
  // only an idle line counts as silence; a frame in flight never advances the timeout
  assign silent  = loading && !rx_valid && !rx_busy;
  assign tmo     = silent && to_q == TO_LAST;
  assign cnt_rx  = {rx_byte, cnt_q[7:0]};
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    idx_d   = idx_q;
    word_d  = word_q;
    err_d   = err_q;
    to_d    = silent ? to_q + 1'b1 : '0;
    if (start_i) begin
      st_d    = L_CNT0;
      words_d = '0;
      err_d   = 1'b0;
    end else if ((rx_ferr && (loading || st_q == L_CNT0)) || tmo) begin
      st_d    = L_CNT0;
      words_d = '0;
      err_d   = 1'b1;
    end else begin
      case (st_q)
        L_CNT0: if (rx_valid) begin
          cnt_d[7:0] = rx_byte;
          st_d       = L_CNT1;
        end
        L_CNT1: if (rx_valid) begin
          cnt_d[15:8] = rx_byte;
          idx_d       = '0;
          err_d       = err_q || cnt_rx > 16'(MAX_WORDS);
          st_d        = cnt_rx == 16'd0 ? L_DONE : cnt_rx > 16'(MAX_WORDS) ? L_CNT0 : L_BYTE;
        end
        L_BYTE: if (rx_valid) begin
          word_d[8*idx_q +: 8] = rx_byte;
          idx_d                = idx_q + 1'b1;
          st_d                 = idx_q == 2'd3 ? L_WRITE : L_BYTE;
        end
        L_WRITE: begin
          words_d = words_q + 16'd1;
          st_d    = words_q + 16'd1 == cnt_q ? L_DONE : L_BYTE;
        end
        L_DONE:  st_d = L_IDLE;
        default: st_d = st_q;
      endcase
    end
  end
  assign wr          = st_q == L_WRITE;
  assign mem.cs      = wr;
  assign mem.we      = {4{wr}};
  assign mem.addr    = wr ? BASE_ADDR + 32'(WORD_BYTES) * 32'(words_q) : '0;
  assign mem.wdata   = wr ? word_q : '0;
  assign mem.drive   = wr;
  assign cpu_hold_o  = st_q != L_IDLE;
  assign load_done_o = st_q == L_DONE;
  assign load_err_o  = err_q;
  assign words_rx_o  = words_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: vector table plus hand sequences, memory writes checked against a scoreboard
module tb_uart_boot_loader;
  typedef struct {
    logic            do_start;
    logic [15:0]     cnt;
    logic [3:0][31:0] w;
    int              nb;
    int              bad;
    int              nw;
    logic            err;
    logic [15:0]     words;
    int              done;
    logic            hold;
  } vec_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  logic clk = 1'b0, rst_n = 1'b0, ser = 1'b1, start = 1'b0;
  logic cpu_hold, load_done, load_err;
  logic [15:0] words_rx;
  int checks = 0, failures = 0, done_cnt = 0, rxv_cnt = 0;
  wr_t sb[$];
  vec_t tv[8];
  uart_boot_loader_if mem();
  uart_boot_loader #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .BASE_ADDR(32'h0), .MAX_WORDS(4), .TIMEOUT_BITS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_i      (ser),
    .start_i    (start),
    .mem        (mem),
    .cpu_hold_o (cpu_hold),
    .load_done_o(load_done),
    .load_err_o (load_err),
    .words_rx_o (words_rx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    wr_t e;
    if (load_done) done_cnt++;
    if (dut.u_rx.rx_valid_o) rxv_cnt++;
    if (mem.cs) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h@%h required=none", mem.wdata, mem.addr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", mem.addr, e.addr);
        chk("wr_data", mem.wdata, e.data);
        chk("wr_we", 32'(mem.we), 32'hF);
        chk("wr_drive", 32'(mem.drive), 32'h1);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic bad);
    ser = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      ser = b[i];
      cyc(16);
    end
    ser = !bad;
    cyc(16);
    ser = 1'b1;
    cyc(4);
  endtask
  task automatic load1(input logic [31:0] w);
    sb.push_back('{addr: 32'h0, data: w});
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask
  function automatic vec_t mk(logic s, logic [15:0] c, logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                              logic [31:0] w3, int nb, int bad, int nw, logic err, logic [15:0] words,
                              int done, logic hold);
    vec_t v;
    v.do_start = s;
    v.cnt = c;
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.w[3] = w3;
    v.nb = nb;
    v.bad = bad;
    v.nw = nw;
    v.err = err;
    v.words = words;
    v.done = done;
    v.hold = hold;
    return v;
  endfunction
  initial begin : watchdog
    repeat (80000) @(posedge clk);
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin : main
    int d0, r0;
    logic [7:0] b;
    logic seen;
    tv[0] = mk(1, 16'd2, 32'h00000013, 32'h00100093, 0, 0, 8, -1, 2, 0, 16'd2, 1, 0);
    tv[1] = mk(1, 16'd5, 0, 0, 0, 0, 0, -1, 0, 1, 16'd0, 0, 1);
    tv[2] = mk(0, 16'd1, 32'hDEADBEEF, 0, 0, 0, 4, -1, 1, 1, 16'd1, 1, 0);
    tv[3] = mk(1, 16'd2, 32'h33221100, 32'h77665544, 0, 0, 3, 4, 0, 1, 16'd0, 0, 1);
    tv[4] = mk(0, 16'd1, 32'h11223344, 0, 0, 0, 4, -1, 1, 1, 16'd1, 1, 0);
    tv[5] = mk(1, 16'd3, 32'hA5A50F0F, 32'h12345678, 0, 0, 6, 7, 1, 1, 16'd0, 0, 1);
    tv[6] = mk(1, 16'd4, 32'h01020304, 32'h8899AABB, 32'hF0E1D2C3, 32'h00FF00FF, 16, -1, 4, 0, 16'd4, 1, 0);
    tv[7] = mk(1, 16'd0, 0, 0, 0, 0, 0, -1, 0, 0, 16'd0, 1, 0);
    cyc(3);
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_cs", 32'(mem.cs), 0);
    chk("rst_we", 32'(mem.we), 0);
    chk("rst_err", 32'(load_err), 0);
    chk("rst_words", 32'(words_rx), 0);
    chk("rst_done", 32'(load_done), 0);
    rst_n = 1'b1;
    cyc(5);
    chk("post_rst_hold", 32'(cpu_hold), 1);
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      if (tv[i].do_start) pulse_start();
      for (int k = 0; k < tv[i].nw; k++) sb.push_back('{addr: 32'(4 * k), data: tv[i].w[k]});
      for (int k = 0; k < tv[i].nb + 2; k++) begin
        if (k < 2) b = tv[i].cnt[8*k +: 8];
        else b = tv[i].w[(k-2)/4][8*((k-2)%4) +: 8];
        send_byte(b, k == tv[i].bad);
      end
      cyc(30);
      chk($sformatf("v%0d_err", i), 32'(load_err), 32'(tv[i].err));
      chk($sformatf("v%0d_words", i), 32'(words_rx), 32'(tv[i].words));
      chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(tv[i].hold));
      chk($sformatf("v%0d_done", i), done_cnt - d0, tv[i].done);
      chk($sformatf("v%0d_sb", i), sb.size(), 0);
    end
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    cyc(40);
    chk("to_early_err", 32'(load_err), 0);
    cyc(40);
    chk("to_err", 32'(load_err), 1);
    chk("to_hold", 32'(cpu_hold), 1);
    d0 = done_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    cyc(30);
    chk("zero_done", done_cnt - d0, 1);
    chk("zero_hold", 32'(cpu_hold), 0);
    chk("zero_sb", sb.size(), 0);
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    pulse_start();
    load1(32'hCAFEF00D);
    cyc(30);
    chk("restart_words", 32'(words_rx), 1);
    chk("restart_err", 32'(load_err), 0);
    chk("restart_hold", 32'(cpu_hold), 0);
    chk("restart_sb", sb.size(), 0);
    pulse_start();
    r0 = rxv_cnt;
    ser = 1'b0;
    cyc(4);
    ser = 1'b1;
    cyc(40);
    chk("glitch_rxv", rxv_cnt - r0, 0);
    load1(32'h0BADF00D);
    cyc(30);
    chk("glitch_load_rxv", rxv_cnt - r0, 6);
    chk("glitch_words", 32'(words_rx), 1);
    chk("glitch_sb", sb.size(), 0);
    pulse_start();
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    cyc(4);
    chk("mid_err_pre", 32'(load_err), 1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    ser = 1'b0;
    cyc(16);
    ser = 1'b1;
    cyc(10);
    rst_n = 1'b0;
    #1;
    chk("midbyte_hold", 32'(cpu_hold), 1);
    chk("midbyte_err", 32'(load_err), 0);
    chk("midbyte_words", 32'(words_rx), 0);
    chk("midbyte_cs", 32'(mem.cs), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(50);
    load1(32'h5EED1234);
    cyc(30);
    chk("midbyte_load_words", 32'(words_rx), 1);
    chk("midbyte_load_sb", sb.size(), 0);
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'h55, 1'b0);
    d0 = done_cnt;
    seen = 1'b0;
    fork
      send_byte(8'h55, 1'b0);
      begin
        for (int t = 0; t < 400 && !seen; t++) begin
          cyc(1);
          if (mem.cs) seen = 1'b1;
        end
        if (seen) begin
          rst_n = 1'b0;
          #1;
          chk("midwr_cs", 32'(mem.cs), 0);
          chk("midwr_we", 32'(mem.we), 0);
          chk("midwr_hold", 32'(cpu_hold), 1);
        end
      end
    join
    chk("midwr_seen", 32'(seen), 1);
    cyc(2);
    rst_n = 1'b1;
    cyc(40);
    chk("midwr_words", 32'(words_rx), 0);
    chk("midwr_done", done_cnt - d0, 0);
    chk("midwr_sb", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
